// File: rtl/ex_op_sequencer.sv
// Issue/completion sequencer between ALU-control decode and the execute units.
package ex_op_sequencer_pkg;

    // Decoded operation select from ALU control; ADD is the reset value.
    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MUL, MULH, MULHSU, MULHU,
        DIV, DIVU, REM, REMU,
        FADD, FSUB, FMUL, FDIV, FSQRT,
        FSGNJ, FSGNJN, FSGNJX, FMIN, FMAX,
        FCVTW, FCVTWU, FCVTSW, FCVTSWU,
        FMVXW, FMVWX, FCLASS, FLE, FLT, FEQ,
        FMADD, FMSUB, FNMSUB, FNMADD
    } alu_t;

    // Execute-unit class codes driven on unit_sel.
    localparam logic [2:0] CLS_INT   = 3'd0;
    localparam logic [2:0] CLS_MUL   = 3'd1;
    localparam logic [2:0] CLS_DIV   = 3'd2;
    localparam logic [2:0] CLS_FADD  = 3'd3;
    localparam logic [2:0] CLS_FMUL  = 3'd4;
    localparam logic [2:0] CLS_FDIV  = 3'd5;
    localparam logic [2:0] CLS_FSQRT = 3'd6;
    localparam logic [2:0] CLS_FMA   = 3'd7;

endpackage

module ex_op_sequencer
    import ex_op_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned DIV_LAT   = 33,
    parameter int unsigned FADD_LAT  = 4,
    parameter int unsigned FMUL_LAT  = 4,
    parameter int unsigned FDIV_LAT  = 24,
    parameter int unsigned FSQRT_LAT = 24,
    parameter int unsigned FMA_LAT   = 5,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_t              in_alu_ctrl,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output alu_t              out_alu_ctrl,
    output logic [TAG_W-1:0]  out_tag,
    output logic [2:0]        unit_sel,
    output logic              unit_start,
    output logic              unit_kill,
    output logic [CNT_W-1:0]  lat_cnt,
    output logic              busy,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    lat_nxt;
    alu_t                op_nxt;
    logic [TAG_W-1:0]    tag_nxt;
    logic [2:0]          sel_nxt;
    logic                start_nxt;
    logic                kill_nxt;
    logic [STAT_W-1:0]   stall_nxt;
    logic [2:0]          in_cls;
    logic [CNT_W-1:0]    in_lat;
    logic                accept;

    // Map an operation onto its execute-unit class; anything unlisted is INT.
    function automatic logic [2:0] op_class(input alu_t op);
        logic [2:0] cls;
        cls = CLS_INT;
        case (op)
            MUL, MULH, MULHSU, MULHU:             cls = CLS_MUL;
            DIV, DIVU, REM, REMU:                 cls = CLS_DIV;
            FADD, FSUB, FCVTW, FCVTWU,
            FCVTSW, FCVTSWU:                      cls = CLS_FADD;
            FMUL:                                 cls = CLS_FMUL;
            FDIV:                                 cls = CLS_FDIV;
            FSQRT:                                cls = CLS_FSQRT;
            FMADD, FMSUB, FNMSUB, FNMADD:         cls = CLS_FMA;
            default:                              cls = CLS_INT;
        endcase
        return cls;
    endfunction

    // Total cycles from accept to out_valid for each class.
    function automatic logic [CNT_W-1:0] class_lat(input logic [2:0] cls);
        logic [CNT_W-1:0] lat;
        case (cls)
            CLS_MUL:   lat = CNT_W'(MUL_LAT);
            CLS_DIV:   lat = CNT_W'(DIV_LAT);
            CLS_FADD:  lat = CNT_W'(FADD_LAT);
            CLS_FMUL:  lat = CNT_W'(FMUL_LAT);
            CLS_FDIV:  lat = CNT_W'(FDIV_LAT);
            CLS_FSQRT: lat = CNT_W'(FSQRT_LAT);
            CLS_FMA:   lat = CNT_W'(FMA_LAT);
            default:   lat = CNT_W'(1);
        endcase
        return lat;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            out_alu_ctrl <= ADD;
            out_tag      <= '0;
            unit_sel     <= CLS_INT;
            unit_start   <= 1'b0;
            unit_kill    <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            lat_cnt      <= lat_nxt;
            out_alu_ctrl <= op_nxt;
            out_tag      <= tag_nxt;
            unit_sel     <= sel_nxt;
            unit_start   <= start_nxt;
            unit_kill    <= kill_nxt;
            stall_cnt    <= stall_nxt;
        end
    end

    // Handshakes, next-state and next-output logic; flush overrides everything.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        op_nxt    = out_alu_ctrl;
        tag_nxt   = out_tag;
        sel_nxt   = unit_sel;
        start_nxt = 1'b0;
        kill_nxt  = 1'b0;

        in_cls    = op_class(in_alu_ctrl);
        in_lat    = class_lat(in_cls);
        in_ready  = !flush && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
        out_valid = (state == S_DONE) && !flush;
        busy      = (state != S_IDLE);
        accept    = in_valid && in_ready;

        stall_nxt = stall_cnt;
        if (in_valid && !in_ready && (stall_cnt != {STAT_W{1'b1}})) begin
            stall_nxt = stall_cnt + STAT_W'(1);
        end

        if (flush) begin
            state_nxt = S_IDLE;
            lat_nxt   = '0;
            kill_nxt  = (state != S_IDLE);
        end else begin
            case (state)
                S_RUN: begin
                    if (lat_cnt == CNT_W'(1)) begin
                        state_nxt = S_DONE;
                        lat_nxt   = '0;
                    end else begin
                        lat_nxt = lat_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) state_nxt = S_IDLE;
                end
                default: ;
            endcase

            if (accept) begin
                op_nxt    = in_alu_ctrl;
                tag_nxt   = in_tag;
                sel_nxt   = in_cls;
                start_nxt = 1'b1;
                if (in_lat == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                    lat_nxt   = '0;
                end else begin
                    state_nxt = S_RUN;
                    lat_nxt   = in_lat - CNT_W'(1);
                end
            end
        end
    end

endmodule
